// File: rtl/dot_product_serial_mac_pkg.sv
// Shared types and width helpers for the serial dot-product engine.
package dot_product_pkg;

  // Controller states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV_A = 3'd1,
    RECV_B = 3'd2,
    MAC    = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Ceiling log2, minimum 0; used for counter and result widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Result width that can hold the full sum without overflow.
  function automatic int out_width(input int elem_width, input int vec_len);
    return 2 * elem_width + clog2(vec_len);
  endfunction

endpackage

// File: rtl/dot_product_serial_mac_if.sv
// Bundle of the serial input, request and result signals of the engine.
//
// Handshake: Start is a one-way request, taken only when the engine is idle
// (Busy=0 and Done=0); a Start seen at any other time is dropped, never queued.
// There is no ready/backpressure on the result side: Done is a one-cycle
// valid for DataOut, and DataOut stays stable until the next run finishes.
interface dot_product_serial_mac_if #(
  parameter int OUT_WIDTH = 19
);
  logic                 SerialData;
  logic                 Start;
  logic                 Busy;
  logic                 Done;
  logic [OUT_WIDTH-1:0] DataOut;
  logic [2:0]           dbg_state;

  modport master (
    output SerialData, Start,
    input  Busy, Done, DataOut, dbg_state
  );

  modport slave (
    input  SerialData, Start,
    output Busy, Done, DataOut, dbg_state
  );
endinterface

// File: rtl/dot_product_serial_mac_mac.sv
// Time-shared multiply-accumulate: extends one element pair to the result
// width, multiplies, and accumulates into a registered sum.
module dot_mac_unit #(
  parameter int ELEM_WIDTH = 8,
  parameter int OUT_WIDTH  = 19,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  output logic [OUT_WIDTH-1:0]  acc,
  output logic [OUT_WIDTH-1:0]  sum_next
);
  localparam int PAD = OUT_WIDTH - ELEM_WIDTH;

  logic                 fill_a;
  logic                 fill_b;
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] b_ext;
  logic [OUT_WIDTH-1:0] product;
  logic [OUT_WIDTH-1:0] acc_q;

  // Extend both operands to the result width; the low OUT_WIDTH bits of the
  // product are the same for signed and unsigned operands once extended.
  always_comb begin
    fill_a   = (SIGNED != 0) && a[ELEM_WIDTH-1];
    fill_b   = (SIGNED != 0) && b[ELEM_WIDTH-1];
    a_ext    = {{PAD{fill_a}}, a};
    b_ext    = {{PAD{fill_b}}, b};
    product  = a_ext * b_ext;
    sum_next = acc_q + product;
  end

  // Accumulator register: cleared at the start of a run, steps when enabled.
  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum_next;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/dot_product_serial_mac.sv
// Serial-input dot-product engine: shifts in vectors A and B one bit per
// cycle, then accumulates A[i]*B[i] one element per cycle.
module dot_product_serial_mac
  import dot_product_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int VEC_LEN    = 8,
  parameter int SIGNED     = 0,
  parameter int OUT_WIDTH  = out_width(ELEM_WIDTH, VEC_LEN)
) (
  input logic clk,
  input logic Reset,
  dot_product_serial_mac_if.slave bus
);
  localparam int BITS  = VEC_LEN * ELEM_WIDTH;
  localparam int CNT_W = clog2(BITS);
  localparam int IDX_W = clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [BITS-1:0]      a_sr_q;
  logic [BITS-1:0]      b_sr_q;
  logic [OUT_WIDTH-1:0] data_out_q;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] sum_next;
  logic [ELEM_WIDTH-1:0] a_elem;
  logic [ELEM_WIDTH-1:0] b_elem;
  logic                 acc_clr;
  logic                 acc_en;

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and accumulator controls.
  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RECV_A;
          acc_clr = 1'b1;
        end
      end
      RECV_A: if (bit_cnt_q == LAST_BIT) state_d = RECV_B;
      RECV_B: if (bit_cnt_q == LAST_BIT) state_d = MAC;
      MAC: begin
        acc_en = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift registers and the held result.
  always_ff @(posedge clk) begin
    if (Reset) begin
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start) bit_cnt_q <= '0;
        end
        RECV_A: begin
          a_sr_q    <= {bus.SerialData, a_sr_q[BITS-1:1]};
          bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        end
        RECV_B: begin
          b_sr_q    <= {bus.SerialData, b_sr_q[BITS-1:1]};
          bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) idx_q <= '0;
        end
        MAC: begin
          if (idx_q == LAST_IDX) begin
            idx_q      <= '0;
            data_out_q <= sum_next;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Element select: the first bit shifted in ends up at bit 0, so element i
  // sits at bits [i*ELEM_WIDTH +: ELEM_WIDTH].
  always_comb begin
    a_elem = a_sr_q[idx_q * ELEM_WIDTH +: ELEM_WIDTH];
    b_elem = b_sr_q[idx_q * ELEM_WIDTH +: ELEM_WIDTH];
  end

  dot_mac_unit #(
    .ELEM_WIDTH (ELEM_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SIGNED     (SIGNED)
  ) u_mac (
    .clk      (clk),
    .Reset    (Reset),
    .clear    (acc_clr),
    .en       (acc_en),
    .a        (a_elem),
    .b        (b_elem),
    .acc      (acc),
    .sum_next (sum_next)
  );

  assign bus.Busy      = (state_q == RECV_A) || (state_q == RECV_B) || (state_q == MAC);
  assign bus.Done      = (state_q == DONE);
  assign bus.DataOut   = data_out_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dot_product_serial_mac.sv
// Bench for the serial dot-product engine: three configurations (unsigned
// 8x8, signed 8x8, unsigned 4x3) against a plain-arithmetic reference.
module tb_dot_product_serial_mac;
  logic       clk;
  logic       Reset;
  logic       ser_data;
  logic [2:0] start_sel;
  int         checks;
  int         errors;
  int         a_el[8];
  int         b_el[8];

  dot_product_serial_mac_if #(.OUT_WIDTH(19)) if_u();
  dot_product_serial_mac_if #(.OUT_WIDTH(19)) if_s();
  dot_product_serial_mac_if #(.OUT_WIDTH(10)) if_c();

  assign if_u.SerialData = ser_data;
  assign if_s.SerialData = ser_data;
  assign if_c.SerialData = ser_data;
  assign if_u.Start      = start_sel[0];
  assign if_s.Start      = start_sel[1];
  assign if_c.Start      = start_sel[2];

  dot_product_serial_mac #(.ELEM_WIDTH(8), .VEC_LEN(8), .SIGNED(0)) u_unsigned (
    .clk(clk), .Reset(Reset), .bus(if_u));
  dot_product_serial_mac #(.ELEM_WIDTH(8), .VEC_LEN(8), .SIGNED(1)) u_signed (
    .clk(clk), .Reset(Reset), .bus(if_s));
  dot_product_serial_mac #(.ELEM_WIDTH(4), .VEC_LEN(3), .SIGNED(0)) u_small (
    .clk(clk), .Reset(Reset), .bus(if_c));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: sum of element products, elements read as W-bit numbers.
  function automatic longint ref_dot(input int w, input int n, input int sgn, input int owid,
                                     input int a_v[8], input int b_v[8]);
    longint s;
    longint x;
    longint y;
    s = 0;
    for (int i = 0; i < n; i++) begin
      x = a_v[i];
      y = b_v[i];
      if (sgn != 0 && x >= (64'sd1 << (w - 1))) x -= (64'sd1 << w);
      if (sgn != 0 && y >= (64'sd1 << (w - 1))) y -= (64'sd1 << w);
      s += x * y;
    end
    return s & ((64'sd1 << owid) - 1);
  endfunction

  task automatic get_obs(input int inst, output logic busy, output logic done,
                         output logic [31:0] dout, output logic [2:0] st);
    case (inst)
      0:       begin busy = if_u.Busy; done = if_u.Done; dout = 32'(if_u.DataOut); st = if_u.dbg_state; end
      1:       begin busy = if_s.Busy; done = if_s.Done; dout = 32'(if_s.DataOut); st = if_s.dbg_state; end
      default: begin busy = if_c.Busy; done = if_c.Done; dout = 32'(if_c.DataOut); st = if_c.dbg_state; end
    endcase
  endtask

  // Drive one run on instance inst: Start in cycle 0, A bits in cycles
  // 1..N*W, B bits in N*W+1..2*N*W (element 0 first, LSB first).
  task automatic run_vec(input int inst, input int w, input int n, input int sgn, input int owid,
                         input int reset_cyc, input bit extra_starts, input string tag);
    int          nw;
    int          exp_done;
    int          done_cnt;
    int          done_at;
    int          k;
    longint      expv;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [31:0] dout_at_done;
    logic [2:0]  st;
    nw       = n * w;
    exp_done = 2 * nw + n + 1;
    done_cnt = 0;
    done_at  = -1;
    dout_at_done = '0;
    expv     = ref_dot(w, n, sgn, owid, a_el, b_el);
    @(negedge clk);
    start_sel      = '0;
    start_sel[inst] = 1'b1;
    for (int c = 1; c <= exp_done + 4; c++) begin
      @(negedge clk);
      get_obs(inst, busy, done, dout, st);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = c;
          dout_at_done = dout;
        end
      end
      if (reset_cyc == 0) begin
        if (c == 1)            check_val({tag, "_busy_c1"}, 32'(busy), 32'd1);
        if (c == exp_done)     check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (c == exp_done + 1) check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
      end else if (c == reset_cyc + 1) begin
        check_val({tag, "_rst_state"}, 32'(st), 32'd0);
        check_val({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_rst_dout"}, dout, 32'd0);
      end
      start_sel = '0;
      Reset     = 1'b0;
      if (c <= nw) begin
        k = c - 1;
        ser_data = 1'((a_el[k / w] >> (k % w)) & 1);
      end else if (c <= 2 * nw) begin
        k = c - 1 - nw;
        ser_data = 1'((b_el[k / w] >> (k % w)) & 1);
      end else begin
        ser_data = 1'($urandom_range(0, 1));
      end
      if (extra_starts && (c == 40 || c == exp_done)) start_sel[inst] = 1'b1;
      if (reset_cyc != 0 && c == reset_cyc) Reset = 1'b1;
    end
    if (reset_cyc == 0) begin
      check_val({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_val({tag, "_done_cyc"}, 32'(done_at), 32'(exp_done));
      check_val({tag, "_dout"}, dout_at_done, 32'(expv));
    end else begin
      check_val({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    end
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int i = 0; i < 8; i++) begin
      a_el[i] = av;
      b_el[i] = bv;
    end
  endtask

  task automatic fill_rand(input int w);
    for (int i = 0; i < 8; i++) begin
      a_el[i] = int'($urandom_range(0, (1 << w) - 1));
      b_el[i] = int'($urandom_range(0, (1 << w) - 1));
    end
  endtask

  // Main sequence.
  initial begin
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [2:0]  st;
    checks    = 0;
    errors    = 0;
    Reset     = 1'b1;
    ser_data  = 1'b0;
    start_sel = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      get_obs(i, busy, done, dout, st);
      check_val($sformatf("reset%0d_busy", i), 32'(busy), 32'd0);
      check_val($sformatf("reset%0d_done", i), 32'(done), 32'd0);
      check_val($sformatf("reset%0d_dout", i), dout, 32'd0);
    end
    Reset = 1'b0;

    fill_const(8'hFF, 8'hFF);
    run_vec(0, 8, 8, 0, 19, 0, 1'b0, "u_all_ff");
    fill_const(8'hFF, 8'h01);
    run_vec(1, 8, 8, 1, 19, 0, 1'b0, "s_neg1");
    fill_const(8'h80, 8'h80);
    run_vec(1, 8, 8, 1, 19, 0, 1'b0, "s_min");
    for (int i = 0; i < 8; i++) begin
      a_el[i] = i + 1;
      b_el[i] = 8 - i;
    end
    run_vec(0, 8, 8, 0, 19, 0, 1'b1, "u_ramp");

    fill_rand(8);
    run_vec(0, 8, 8, 0, 19, 90, 1'b0, "u_reset");
    fill_rand(8);
    run_vec(0, 8, 8, 0, 19, 0, 1'b0, "u_after_rst");

    for (int t = 0; t < 3; t++) begin
      fill_rand(8);
      run_vec(0, 8, 8, 0, 19, 0, 1'b0, $sformatf("u_rand%0d", t));
      fill_rand(8);
      run_vec(1, 8, 8, 1, 19, 0, 1'b0, $sformatf("s_rand%0d", t));
    end
    for (int t = 0; t < 2; t++) begin
      fill_rand(4);
      run_vec(2, 4, 3, 0, 10, 0, 1'b0, $sformatf("c_rand%0d", t));
    end

    fill_const(15, 15);
    run_vec(2, 4, 3, 0, 10, 0, 1'b0, "c_all_f");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      get_obs(2, busy, done, dout, st);
      check_val($sformatf("c_hold%0d", c), dout, 32'(ref_dot(4, 3, 0, 10, a_el, b_el)));
      check_val($sformatf("c_hold_done%0d", c), 32'(done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
